// File: rtl/node_pkg.sv
// rtl/node_pkg.sv - shared encodings and types for the node port controller
//
// Purpose : direction codes, word width and FSM state type shared by
//           node_port_ctrl and its sub-modules.
// Ports   : none (package)
package node_pkg;

   localparam int DATA_W = 12;
   localparam int NDIR   = 4;

   localparam logic [2:0] DIR_UP    = 3'd0;
   localparam logic [2:0] DIR_DOWN  = 3'd1;
   localparam logic [2:0] DIR_LEFT  = 3'd2;
   localparam logic [2:0] DIR_RIGHT = 3'd3;
   localparam logic [2:0] DIR_ANY   = 3'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_WAIT = 2'd1,
      RD_WAIT = 2'd2,
      FINISH  = 2'd3
   } state_t;

endpackage

// File: rtl/prio_enc4.sv
// rtl/prio_enc4.sv - 4-bit lowest-index priority encoder with multi-hit flag
//
// Purpose : picks the lowest-index set bit of a 4-bit request vector.
// Ports   : req_i   [3:0] request bits
//           idx_o   [1:0] index of lowest set bit (0 when none set)
//           valid_o       at least one bit set
//           multi_o       more than one bit set
module prio_enc4 (
   input  logic [3:0] req_i,
   output logic [1:0] idx_o,
   output logic       valid_o,
   output logic       multi_o
);

   always_comb begin
      idx_o = 2'd0;
      if (req_i[0])      idx_o = 2'd0;
      else if (req_i[1]) idx_o = 2'd1;
      else if (req_i[2]) idx_o = 2'd2;
      else if (req_i[3]) idx_o = 2'd3;
   end

   assign valid_o = |req_i;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_o = |(req_i & (req_i - 4'd1));

endmodule

// File: rtl/node_port_ctrl.sv
// rtl/node_port_ctrl.sv - node-side four-direction word transfer handshake controller
//
// Purpose : accepts one directional/ANY read or write from the core and runs
//           the data_ready/ack_read (send) or request_write/ack_write (receive)
//           handshake against the up/down/left/right neighbours.
// Ports   : clk, rst_n                       clock, sync active-low reset
//           cmd_valid/ready/write/dir/data    core command interface
//           done, rd_data, last_dir           completion pulse, read word, winning direction
//           err, multi_ack                    illegal-direction and ANY-write collision pulses
//           tx_*, data_ready, ack_read        send handshake per direction
//           rx_*, request_write, ack_write    receive handshake per direction
module node_port_ctrl
   import node_pkg::*;
#(
   parameter int DATA_W = node_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [2:0]        cmd_dir,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic [1:0]        last_dir,
   output logic              err,
   output logic              multi_ack,
   output logic [DATA_W-1:0] tx_up,
   output logic [DATA_W-1:0] tx_down,
   output logic [DATA_W-1:0] tx_left,
   output logic [DATA_W-1:0] tx_right,
   output logic [NDIR-1:0]   data_ready,
   input  logic [NDIR-1:0]   ack_read,
   input  logic [DATA_W-1:0] rx_up,
   input  logic [DATA_W-1:0] rx_down,
   input  logic [DATA_W-1:0] rx_left,
   input  logic [DATA_W-1:0] rx_right,
   input  logic [NDIR-1:0]   request_write,
   output logic [NDIR-1:0]   ack_write
);

   state_t              state_q;
   logic                is_any_q;
   logic [1:0]          dir_q;
   logic [DATA_W-1:0]   tx_up_q, tx_down_q, tx_left_q, tx_right_q;
   logic [NDIR-1:0]     data_ready_q;
   logic [NDIR-1:0]     ack_write_q;
   logic                done_q, err_q, multi_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic [1:0]          last_dir_q;

   logic [NDIR-1:0]     accept_mask;
   logic [NDIR-1:0]     rd_mask;
   logic [NDIR-1:0]     pe_req;
   logic [1:0]          win_idx;
   logic                win_valid;
   logic                win_multi;
   logic [DATA_W-1:0]   rx_sel;

   // Directions the accepted command will drive: all four for ANY, else one-hot.
   assign accept_mask = (cmd_dir == DIR_ANY) ? 4'b1111 : (4'b0001 << cmd_dir[1:0]);
   assign rd_mask     = is_any_q ? 4'b1111 : (4'b0001 << dir_q);

   // One encoder serves both wait states; ack_read is masked by data_ready so
   // an ack on a direction we are not offering cannot win.
   assign pe_req = (state_q == WR_WAIT) ? (ack_read & data_ready_q) :
                   (state_q == RD_WAIT) ? (request_write & rd_mask) : 4'b0000;

   prio_enc4 u_prio (
      .req_i   (pe_req),
      .idx_o   (win_idx),
      .valid_o (win_valid),
      .multi_o (win_multi)
   );

   always_comb begin
      rx_sel = rx_up;
      case (win_idx)
         2'd0: rx_sel = rx_up;
         2'd1: rx_sel = rx_down;
         2'd2: rx_sel = rx_left;
         2'd3: rx_sel = rx_right;
         default: rx_sel = rx_up;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         is_any_q     <= 1'b0;
         dir_q        <= 2'd0;
         tx_up_q      <= '0;
         tx_down_q    <= '0;
         tx_left_q    <= '0;
         tx_right_q   <= '0;
         data_ready_q <= '0;
         ack_write_q  <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         multi_q      <= 1'b0;
         rd_data_q    <= '0;
         last_dir_q   <= 2'd0;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         multi_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_dir > DIR_ANY) begin
                     err_q <= 1'b1;
                  end else begin
                     is_any_q <= (cmd_dir == DIR_ANY);
                     dir_q    <= cmd_dir[1:0];
                     if (cmd_write) begin
                        data_ready_q <= accept_mask;
                        tx_up_q      <= accept_mask[0] ? cmd_data : '0;
                        tx_down_q    <= accept_mask[1] ? cmd_data : '0;
                        tx_left_q    <= accept_mask[2] ? cmd_data : '0;
                        tx_right_q   <= accept_mask[3] ? cmd_data : '0;
                        state_q      <= WR_WAIT;
                     end else begin
                        state_q      <= RD_WAIT;
                     end
                  end
               end
            end
            WR_WAIT: begin
               if (win_valid) begin
                  data_ready_q <= '0;
                  tx_up_q      <= '0;
                  tx_down_q    <= '0;
                  tx_left_q    <= '0;
                  tx_right_q   <= '0;
                  done_q       <= 1'b1;
                  last_dir_q   <= win_idx;
                  multi_q      <= is_any_q & win_multi;
                  state_q      <= FINISH;
               end
            end
            RD_WAIT: begin
               if (win_valid) begin
                  ack_write_q <= 4'b0001 << win_idx;
                  rd_data_q   <= rx_sel;
                  done_q      <= 1'b1;
                  last_dir_q  <= win_idx;
                  state_q     <= FINISH;
               end
            end
            FINISH: begin
               // Re-arm gap: request_write is not looked at again until the
               // next command reaches RD_WAIT.
               ack_write_q  <= '0;
               data_ready_q <= '0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign done       = done_q;
   assign rd_data    = rd_data_q;
   assign last_dir   = last_dir_q;
   assign err        = err_q;
   assign multi_ack  = multi_q;
   assign tx_up      = tx_up_q;
   assign tx_down    = tx_down_q;
   assign tx_left    = tx_left_q;
   assign tx_right   = tx_right_q;
   assign data_ready = data_ready_q;
   assign ack_write  = ack_write_q;

endmodule

// File: tb/tb_node_port_ctrl.sv
// tb/tb_node_port_ctrl.sv - directed scoreboard bench for node_port_ctrl
module tb_node_port_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [2:0]  cmd_dir;
   logic [11:0] cmd_data;
   logic        done, err, multi_ack;
   logic [11:0] rd_data;
   logic [1:0]  last_dir;
   logic [11:0] tx_up, tx_down, tx_left, tx_right;
   logic [3:0]  data_ready, ack_read, request_write, ack_write;
   logic [11:0] rx_up, rx_down, rx_left, rx_right;

   typedef struct {
      logic        wr;
      logic [1:0]  dir;
      logic [11:0] data;
      logic        multi;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   node_port_ctrl #(.DATA_W(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_dir(cmd_dir), .cmd_data(cmd_data),
      .done(done), .rd_data(rd_data), .last_dir(last_dir),
      .err(err), .multi_ack(multi_ack),
      .tx_up(tx_up), .tx_down(tx_down), .tx_left(tx_left), .tx_right(tx_right),
      .data_ready(data_ready), .ack_read(ack_read),
      .rx_up(rx_up), .rx_down(rx_down), .rx_left(rx_left), .rx_right(rx_right),
      .request_write(request_write), .ack_write(ack_write)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Caller sits at a negedge with the DUT idle; returns one negedge later.
   task automatic do_cmd(input logic wr, input logic [2:0] dir, input logic [11:0] data);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_dir   = dir;
      cmd_data  = data;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Waits for done, pops the scoreboard and compares, then confirms re-arm.
   task automatic wait_done(input string tag);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_sb"}, sb.size(), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_last_dir"}, {30'd0, last_dir}, {30'd0, e.dir});
         check({tag, "_multi"}, {31'd0, multi_ack}, {31'd0, e.multi});
         check({tag, "_dready"}, {28'd0, data_ready}, 32'd0);
         if (e.wr) begin
            check({tag, "_ackw"}, {28'd0, ack_write}, 32'd0);
         end else begin
            check({tag, "_rd_data"}, {20'd0, rd_data}, {20'd0, e.data});
            check({tag, "_ackw"}, {28'd0, ack_write}, {28'd0, 4'b0001 << e.dir});
         end
      end
      ack_read      = 4'b0000;
      request_write = 4'b0000;
      @(negedge clk);
      check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
      check({tag, "_ackw_drop"}, {28'd0, ack_write}, 32'd0);
      check({tag, "_ready_again"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_dir = 3'd0; cmd_data = 12'd0;
      ack_read = 4'b0000; request_write = 4'b0000;
      rx_up = 12'd0; rx_down = 12'd0; rx_left = 12'd0; rx_right = 12'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_dready", {28'd0, data_ready}, 32'd0);
      check("rst_ackw", {28'd0, ack_write}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rd_data", {20'd0, rd_data}, 32'd0);
      check("rst_tx_left", {20'd0, tx_left}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directional write left, -5; stray acks on other directions ignored
      do_cmd(1'b1, 3'd2, 12'hFFB);
      check("wr_dready", {28'd0, data_ready}, 32'h4);
      check("wr_tx_left", {20'd0, tx_left}, 32'hFFB);
      check("wr_tx_up", {20'd0, tx_up}, 32'd0);
      check("wr_tx_right", {20'd0, tx_right}, 32'd0);
      check("wr_busy", {31'd0, cmd_ready}, 32'd0);
      ack_read = 4'b1011;
      @(negedge clk);
      check("wr_stray_nodone", {31'd0, done}, 32'd0);
      check("wr_stray_dready", {28'd0, data_ready}, 32'h4);
      ack_read = 4'b0100;
      sb.push_back('{wr: 1'b1, dir: 2'd2, data: 12'hFFB, multi: 1'b0});
      wait_done("wr_left");

      // Directional read down, with a busy command ignored meanwhile
      do_cmd(1'b0, 3'd1, 12'd0);
      check("rd_busy", {31'd0, cmd_ready}, 32'd0);
      do_cmd(1'b1, 3'd0, 12'h055);
      check("rd_busy_no_dready", {28'd0, data_ready}, 32'd0);
      check("rd_busy_no_ackw", {28'd0, ack_write}, 32'd0);
      rx_down = 12'h123;
      request_write = 4'b0010;
      sb.push_back('{wr: 1'b0, dir: 2'd1, data: 12'h123, multi: 1'b0});
      wait_done("rd_down");
      check("rd_hold", {20'd0, rd_data}, 32'h123);

      // ANY read priority
      rx_down = 12'h456; rx_right = 12'h789;
      do_cmd(1'b0, 3'd4, 12'd0);
      request_write = 4'b1010;
      sb.push_back('{wr: 1'b0, dir: 2'd1, data: 12'h456, multi: 1'b0});
      wait_done("any_rd_1010");
      do_cmd(1'b0, 3'd4, 12'd0);
      request_write = 4'b1000;
      sb.push_back('{wr: 1'b0, dir: 2'd3, data: 12'h789, multi: 1'b0});
      wait_done("any_rd_1000");

      // ANY write collision
      do_cmd(1'b1, 3'd4, 12'h7FF);
      check("anywr_dready", {28'd0, data_ready}, 32'hF);
      check("anywr_tx_up", {20'd0, tx_up}, 32'h7FF);
      check("anywr_tx_down", {20'd0, tx_down}, 32'h7FF);
      check("anywr_tx_right", {20'd0, tx_right}, 32'h7FF);
      ack_read = 4'b0110;
      sb.push_back('{wr: 1'b1, dir: 2'd1, data: 12'h7FF, multi: 1'b1});
      wait_done("any_wr");

      // Illegal direction
      do_cmd(1'b1, 3'd6, 12'h111);
      check("ill_err", {31'd0, err}, 32'd1);
      check("ill_dready", {28'd0, data_ready}, 32'd0);
      check("ill_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      check("ill_err_drop", {31'd0, err}, 32'd0);
      check("ill_ackw", {28'd0, ack_write}, 32'd0);

      // Reset mid-transfer
      do_cmd(1'b1, 3'd4, 12'h321);
      check("rstmid_dready", {28'd0, data_ready}, 32'hF);
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid_dready0", {28'd0, data_ready}, 32'd0);
      check("rstmid_tx_up0", {20'd0, tx_up}, 32'd0);
      check("rstmid_done", {31'd0, done}, 32'd0);
      check("rstmid_last_dir", {30'd0, last_dir}, 32'd0);
      check("rstmid_rd_data", {20'd0, rd_data}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
      check("rstmid_nodone", {31'd0, done}, 32'd0);

      check("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/node_port_ctrl.md
Name: node_port_ctrl

Overview:
Node-side endpoint of the four-direction (up/down/left/right) word-transfer handshake that the stack memory and other grid nodes expose. A compute core issues one directional read or write, or an ANY read or write. The block sequences the dataReady/ackRead handshake (node sends) and the requestWrite/ackWrite handshake (node receives) against the four neighbours. It sits between a node's execution core and its four neighbour links.

Parameters:
DATA_W, 12, signed data word width
NDIR, 4, number of directions (fixed 4; index 0=up 1=down 2=left 3=right)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
cmd_valid  in  1  core request strobe, accepted when cmd_ready=1
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=send word to neighbour, 0=receive word from neighbour
cmd_dir  in  3  0..3 direction, 4=ANY, 5..7 illegal
cmd_data  in  DATA_W  signed word to send
done  out  1  one-cycle completion pulse
rd_data  out  DATA_W  received word, valid with done on reads, held until next read completes
last_dir  out  2  direction that completed the most recent transfer
err  out  1  one-cycle pulse on illegal cmd_dir
multi_ack  out  1  one-cycle pulse when an ANY write saw >1 ackRead in the winning cycle
tx_up/tx_down/tx_left/tx_right  out  DATA_W  outgoing word per direction
data_ready  out  4  per-direction "word available" to neighbour
ack_read  in  4  neighbour consumed the word
rx_up/rx_down/rx_left/rx_right  in  DATA_W  neighbour's outgoing word
request_write  in  4  neighbour has a word for this node
ack_write  out  4  this node accepted the neighbour's word

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; data_ready=0, ack_write=0, done=0, err=0, multi_ack=0, tx_*=0, rd_data=0, last_dir=0. Applies mid-transfer: an in-flight handshake is dropped and no done is issued.
- States: IDLE, WR_WAIT, RD_WAIT, FINISH.
- IDLE: on cmd_valid with cmd_dir<=4, latch cmd_write, dir and data. Go to WR_WAIT if cmd_write=1, else RD_WAIT. With cmd_dir>4: pulse err next cycle, stay IDLE.
- WR_WAIT: the latched word drives tx_* of the target direction. For ANY it drives all four tx_* and data_ready=4'b1111; otherwise only the target data_ready bit is set. Non-target tx_* hold 0. Entered the cycle after accept, so data_ready rises at accept+1.
  - Winner = lowest-index bit of (ack_read & data_ready).
  - On winner: next cycle data_ready=0, done=1, last_dir=winner, go FINISH.
  - ANY with >1 ack_read bit set that cycle: multi_ack pulses with done.
  - ack_read on a direction not in data_ready is ignored.
- RD_WAIT: sample request_write.
  - Directional: wait for request_write[dir].
  - ANY: winner = lowest-index set bit.
  - On winner: next cycle ack_write[winner]=1 for exactly one cycle, rd_data=rx of winner (latched on the sampling edge), done=1, last_dir=winner, go FINISH.
- FINISH: one cycle, all handshake outputs 0, then IDLE. This is the re-arm gap: a still-high request_write is not resampled until the next command's RD_WAIT, at least 2 cycles after ack_write. Peers must drop request_write within 1 cycle of ack_write.
- Throughput: one transfer per 3 cycles minimum (accept, wait≥1, finish).
- No timeout: WR_WAIT and RD_WAIT block indefinitely. Only reset aborts.
- cmd_valid while cmd_ready=0 is ignored (not queued).
- Data pass-through: no arithmetic, signed words forwarded bit-exact.

Decomposition:
- Shared package node_pkg holds:
  - direction encodings DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3, DIR_ANY=4
  - DATA_W=12
  - state enum {IDLE, WR_WAIT, RD_WAIT, FINISH}
- One sub-module prio_enc4: 4-bit request in, 2-bit lowest-index winner plus any-valid and multi flags. It is shared by the ANY-write winner and ANY-read winner paths.

Test Plan:
- Directional write: cmd write dir=2 data=-5 (0xFFB), ack_read[2] raised 3 cycles later -> data_ready=4'b0100 from accept+1, tx_left=0xFFB, done one cycle after ack, last_dir=2, data_ready=0.
- Directional read: cmd read dir=1; request_write[1]=1 with rx_down=0x123 -> ack_write=4'b0010 for one cycle, rd_data=0x123, done together, last_dir=1.
- ANY read priority: request_write=4'b1010 simultaneously -> winner=1 (down), ack_write=4'b0010 only. A follow-up ANY read with request_write=4'b1000 -> winner=3.
- ANY write collision: data 0x7FF, ack_read=4'b0110 same cycle -> last_dir=1, done and multi_ack pulse, data_ready all drop next cycle.
- Illegal and busy commands: cmd_dir=6 -> err pulse, no data_ready/ack_write activity. A cmd_valid during RD_WAIT -> ignored, cmd_ready=0.
- Reset mid-transfer: rst_n=0 during WR_WAIT with data_ready=4'b1111 -> next edge all outputs 0, no done, cmd_ready=1 after rst_n=1.
